block_drawer: RTL and testbench

//   Downstream of the x/y/colour load stage; feeds the VGA adapter write port.
//   On a start pulse, latches one block origin (x,y) and colour, then rasters a

---
 rtl/blockstacker_pkg.sv | 22 ++
 rtl/block_drawer_if.sv | 28 ++
 rtl/block_pixel_counter.sv | 48 ++++
 rtl/block_drawer.sv | 142 ++++++++++++++
 tb/tb_block_drawer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blockstacker_pkg.sv
// Shared definitions for the block stacker datapath: screen and block
// geometry, the colour type, and the block drawer state encoding.
package blockstacker_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int BLOCK_W  = 4;
    localparam int BLOCK_H  = 4;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef logic [2:0] colour_t;
    localparam colour_t COLOUR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } drawer_state_t;

endpackage

// File: rtl/block_drawer_if.sv
// Request/pixel bus between the x/y/colour load stage (master) and the
// block drawer (slave). The pixel side feeds the VGA adapter write port.
interface block_drawer_if;
    import blockstacker_pkg::*;

    logic                start;
    logic [X_W-1:0]      x_in;
    logic [Y_W-1:0]      y_in;
    colour_t             colour_in;

    logic                ready;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    colour_t             colour_out;
    logic                plot;
    logic                done;

    modport master (
        output start, x_in, y_in, colour_in,
        input  ready, x_out, y_out, colour_out, plot, done
    );

    modport slave (
        input  start, x_in, y_in, colour_in,
        output ready, x_out, y_out, colour_out, plot, done
    );

endinterface

// File: rtl/block_pixel_counter.sv
// Row-major cx/cy counter over a BLOCK_W x BLOCK_H block. Exposes the
// coordinates the counter will hold after the next enabled step, so the
// drawer can register the matching pixel in the same edge, plus 'last'
// while the counter sits on the final pixel.
module block_pixel_counter #(
    parameter int BLOCK_W = 4,
    parameter int BLOCK_H = 4,
    parameter int CXW     = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1,
    parameter int CYW     = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           en,
    output logic [CXW-1:0] nx,
    output logic [CYW-1:0] ny,
    output logic           last
);

    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic           col_wrap;
    logic           row_end;

    // Next coordinate: column wraps at BLOCK_W-1 and carries into the row.
    always_comb begin
        col_wrap = (cx == CXW'(BLOCK_W - 1));
        row_end  = (cy == CYW'(BLOCK_H - 1));
        nx       = col_wrap ? '0 : cx + 1'b1;
        ny       = cy;
        if (col_wrap) begin
            ny = row_end ? '0 : cy + 1'b1;
        end
        last     = col_wrap && row_end;
    end

    // Counter state; clear wins over enable so the block always starts at (0,0).
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            cx <= nx;
            cy <= ny;
        end
    end

endmodule

// File: rtl/block_drawer.sv
// Block drawer: latches an origin and colour on start, then rasters a
// BLOCK_W x BLOCK_H square one pixel per clock into the VGA write port and
// pulses done afterwards. All outputs are registered.
// Optional feature: define BLOCK_DRAWER_CLIP_EN to suppress plot for pixels
// that fall outside SCREEN_W x SCREEN_H (the cycle is still spent).
module block_drawer
    import blockstacker_pkg::*;
#(
    parameter int BLOCK_W  = blockstacker_pkg::BLOCK_W,
    parameter int BLOCK_H  = blockstacker_pkg::BLOCK_H,
    parameter int SCREEN_W = blockstacker_pkg::SCREEN_W,
    parameter int SCREEN_H = blockstacker_pkg::SCREEN_H
) (
    input  logic          clk,
    input  logic          reset,
    block_drawer_if.slave bus
);

    localparam int CXW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int CYW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

`ifdef BLOCK_DRAWER_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    drawer_state_t  state, state_nx;

    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    colour_t        c0;

    logic [CXW-1:0] nx;
    logic [CYW-1:0] ny;
    logic           last;

    logic [X_W-1:0] base_x;
    logic [Y_W-1:0] base_y;
    colour_t        base_c;
    logic [CXW-1:0] off_x;
    logic [CYW-1:0] off_y;
    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic           on_screen;
    logic           in_view;

    logic           ready_d, plot_d, done_d;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    colour_t        colour_d;

    block_pixel_counter #(
        .BLOCK_W (BLOCK_W),
        .BLOCK_H (BLOCK_H),
        .CXW     (CXW),
        .CYW     (CYW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (state != DRAW),
        .en    (state == DRAW),
        .nx    (nx),
        .ny    (ny),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, plus the pixel that will be presented next cycle. In IDLE
    // the first pixel comes straight from the inputs since the origin latch
    // only updates at the same edge.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = DRAW;
            DRAW:    if (last)      state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase

        base_x = (state == IDLE) ? bus.x_in      : x0;
        base_y = (state == IDLE) ? bus.y_in      : y0;
        base_c = (state == IDLE) ? bus.colour_in : c0;
        off_x  = (state == IDLE) ? '0 : nx;
        off_y  = (state == IDLE) ? '0 : ny;

        // Sums are one bit wider so clipping sees the true coordinate; the
        // outputs drop the top bit and wrap.
        x_sum     = {1'b0, base_x} + (X_W+1)'(off_x);
        y_sum     = {1'b0, base_y} + (Y_W+1)'(off_y);
        on_screen = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
        in_view   = !CLIP_ON || on_screen;

        ready_d  = (state_nx == IDLE);
        done_d   = (state_nx == DONE);
        plot_d   = (state_nx == DRAW) && in_view;
        x_d      = (state_nx == DRAW) ? x_sum[X_W-1:0] : '0;
        y_d      = (state_nx == DRAW) ? y_sum[Y_W-1:0] : '0;
        colour_d = (state_nx == DRAW) ? base_c : COLOUR_BLACK;
    end

    // Origin/colour latch; only a start seen while ready is taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x0 <= '0;
            y0 <= '0;
            c0 <= COLOUR_BLACK;
        end else if (state == IDLE && bus.start) begin
            x0 <= bus.x_in;
            y0 <= bus.y_in;
            c0 <= bus.colour_in;
        end
    end

    // Registered outputs to the VGA adapter and the upstream handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.ready      <= 1'b1;
            bus.plot       <= 1'b0;
            bus.done       <= 1'b0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= COLOUR_BLACK;
        end else begin
            bus.ready      <= ready_d;
            bus.plot       <= plot_d;
            bus.done       <= done_d;
            bus.x_out      <= x_d;
            bus.y_out      <= y_d;
            bus.colour_out <= colour_d;
        end
    end

endmodule

// File: tb/tb_block_drawer.sv
// Directed bench for block_drawer: reset values, basic raster, ignored
// starts, reset mid-draw, erase at screen edge, clipping/wrap behaviour and
// input isolation after the latch cycle.
module tb_block_drawer;
    import blockstacker_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    block_drawer_if bus();

    block_drawer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one cycle; returns in the first DRAW cycle.
    task automatic issue(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.start     = 1'b1;
        bus.x_in      = x;
        bus.y_in      = y;
        bus.colour_in = c;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.x_in = 8'd77; bus.y_in = 7'd33; bus.colour_in = 3'd7;
        tick(); tick(); tick();
        total++;
        if (bus.ready !== 1'b1 || bus.plot !== 1'b0 || bus.done !== 1'b0 ||
            bus.x_out !== 8'd0 || bus.y_out !== 7'd0 || bus.colour_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_vals got rdy=%b plot=%b done=%b x=%0d y=%0d c=%0d want 1 0 0 0 0 0",
                     bus.ready, bus.plot, bus.done, bus.x_out, bus.y_out, bus.colour_out);
        end
        reset = 1'b1;
        tick();
        total++;
        if (bus.ready !== 1'b1 || bus.plot !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got rdy=%b plot=%b done=%b want 1 0 0", bus.ready, bus.plot, bus.done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ex;
        logic [6:0] ey;
        issue(8'd8, 7'd100, 3'b101);
        for (int k = 0; k < 16; k++) begin
            ex = 8'(8 + k % 4);
            ey = 7'(100 + k / 4);
            total++;
            if (bus.plot !== 1'b1 || bus.x_out !== ex || bus.y_out !== ey || bus.colour_out !== 3'b101 ||
                bus.ready !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL basic_pix k=%0d got plot=%b x=%0d y=%0d c=%0d rdy=%b done=%b want 1 %0d %0d 5 0 0",
                         k, bus.plot, bus.x_out, bus.y_out, bus.colour_out, bus.ready, bus.done, ex, ey);
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.plot !== 1'b0 || bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got done=%b plot=%b rdy=%b want 1 0 0", bus.done, bus.plot, bus.ready);
        end
        tick();
        total++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.plot !== 1'b0 || bus.colour_out !== 3'd0) begin
            bad++;
            $display("FAIL basic_ready got rdy=%b done=%b plot=%b c=%0d want 1 0 0 0",
                     bus.ready, bus.done, bus.plot, bus.colour_out);
        end
    endtask

    task automatic test_start_held();
        logic [7:0] ex;
        logic [6:0] ey;
        issue(8'd8, 7'd20, 3'd1);
        // Start stays high with other coordinates for the whole DRAW/DONE window.
        bus.start = 1'b1; bus.x_in = 8'd50; bus.y_in = 7'd50; bus.colour_in = 3'd7;
        for (int k = 0; k < 16; k++) begin
            ex = 8'(8 + k % 4);
            ey = 7'(20 + k / 4);
            total++;
            if (bus.plot !== 1'b1 || bus.x_out !== ex || bus.y_out !== ey || bus.colour_out !== 3'd1) begin
                bad++;
                $display("FAIL held_pix k=%0d got plot=%b x=%0d y=%0d c=%0d want 1 %0d %0d 1",
                         k, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.plot !== 1'b0 || bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL held_done got done=%b plot=%b rdy=%b want 1 0 0", bus.done, bus.plot, bus.ready);
        end
        tick();
        total++;
        if (bus.ready !== 1'b1 || bus.plot !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL held_idle got rdy=%b plot=%b done=%b want 1 0 0", bus.ready, bus.plot, bus.done);
        end
        // Start is still high here, so this IDLE cycle accepts the new origin.
        bus.x_in = 8'd20; bus.y_in = 7'd30; bus.colour_in = 3'd2;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.plot !== 1'b1 || bus.x_out !== 8'd20 || bus.y_out !== 7'd30 || bus.colour_out !== 3'd2 ||
            bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL held_second got plot=%b x=%0d y=%0d c=%0d rdy=%b want 1 20 30 2 0",
                     bus.plot, bus.x_out, bus.y_out, bus.colour_out, bus.ready);
        end
        for (int k = 0; k < 16; k++) tick();
        total++;
        if (bus.done !== 1'b1 || bus.plot !== 1'b0) begin
            bad++;
            $display("FAIL held_second_done got done=%b plot=%b want 1 0", bus.done, bus.plot);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] ex;
        logic [6:0] ey;
        int         plots;
        issue(8'd30, 7'd40, 3'd6);
        tick(); tick(); tick(); tick();
        total++;
        if (bus.plot !== 1'b1 || bus.x_out !== 8'd30 || bus.y_out !== 7'd41) begin
            bad++;
            $display("FAIL rmid_fifth got plot=%b x=%0d y=%0d want 1 30 41", bus.plot, bus.x_out, bus.y_out);
        end
        reset = 1'b0;
        tick();
        total++;
        if (bus.plot !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1 ||
            bus.x_out !== 8'd0 || bus.y_out !== 7'd0 || bus.colour_out !== 3'd0) begin
            bad++;
            $display("FAIL rmid_reset got plot=%b done=%b rdy=%b x=%0d y=%0d c=%0d want 0 0 1 0 0 0",
                     bus.plot, bus.done, bus.ready, bus.x_out, bus.y_out, bus.colour_out);
        end
        reset = 1'b1;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.plot !== 1'b0 || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_nodone got done=%b plot=%b rdy=%b want 0 0 1", bus.done, bus.plot, bus.ready);
        end
        issue(8'd30, 7'd40, 3'd6);
        plots = 0;
        for (int k = 0; k < 16; k++) begin
            ex = 8'(30 + k % 4);
            ey = 7'(40 + k / 4);
            if (bus.plot === 1'b1 && bus.x_out === ex && bus.y_out === ey && bus.colour_out === 3'd6)
                plots++;
            tick();
        end
        total++;
        if (plots != 16 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL rmid_redraw got good_pixels=%0d done=%b want 16 1", plots, bus.done);
        end
        tick();
    endtask

    task automatic test_erase();
        logic [7:0] ex;
        logic [6:0] ey;
        int         dones;
        issue(8'd156, 7'd116, 3'b000);
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            ex = 8'(156 + k % 4);
            ey = 7'(116 + k / 4);
            if (bus.done === 1'b1) dones++;
            total++;
            if (bus.plot !== 1'b1 || bus.x_out !== ex || bus.y_out !== ey || bus.colour_out !== 3'd0) begin
                bad++;
                $display("FAIL erase_pix k=%0d got plot=%b x=%0d y=%0d c=%0d want 1 %0d %0d 0",
                         k, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
            end
            tick();
        end
        if (bus.done === 1'b1) dones++;
        tick();
        if (bus.done === 1'b1) dones++;
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL erase_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_clip();
        logic [7:0] ex;
        logic [6:0] ey;
        logic       ep;
        issue(8'd158, 7'd10, 3'd3);
        for (int k = 0; k < 16; k++) begin
            ex = 8'(158 + k % 4);
            ey = 7'(10 + k / 4);
`ifdef BLOCK_DRAWER_CLIP_EN
            ep = ((158 + k % 4) < 160);
`else
            ep = 1'b1;
`endif
            total++;
            if (bus.plot !== ep || (ep && (bus.x_out !== ex || bus.y_out !== ey || bus.colour_out !== 3'd3))) begin
                bad++;
                $display("FAIL clip_pix k=%0d got plot=%b x=%0d y=%0d c=%0d want %b %0d %0d 3",
                         k, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ep, ex, ey);
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.plot !== 1'b0) begin
            bad++;
            $display("FAIL clip_done got done=%b plot=%b want 1 0", bus.done, bus.plot);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] ex;
        logic [6:0] ey;
        logic       ep;
        issue(8'd254, 7'd126, 3'd1);
        for (int k = 0; k < 16; k++) begin
            ex = 8'(254 + k % 4);
            ey = 7'(126 + k / 4);
`ifdef BLOCK_DRAWER_CLIP_EN
            ep = 1'b0;
`else
            ep = 1'b1;
`endif
            total++;
            if (bus.plot !== ep || (ep && (bus.x_out !== ex || bus.y_out !== ey))) begin
                bad++;
                $display("FAIL wrap_pix k=%0d got plot=%b x=%0d y=%0d want %b %0d %0d",
                         k, bus.plot, bus.x_out, bus.y_out, ep, ex, ey);
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL wrap_done got done=%b want 1", bus.done);
        end
        tick();
    endtask

    task automatic test_scramble();
        logic [7:0] ex;
        logic [6:0] ey;
        issue(8'd40, 7'd60, 3'd6);
        for (int k = 0; k < 16; k++) begin
            ex = 8'(40 + k % 4);
            ey = 7'(60 + k / 4);
            total++;
            if (bus.plot !== 1'b1 || bus.x_out !== ex || bus.y_out !== ey || bus.colour_out !== 3'd6) begin
                bad++;
                $display("FAIL scramble_pix k=%0d got plot=%b x=%0d y=%0d c=%0d want 1 %0d %0d 6",
                         k, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
            end
            bus.x_in      = 8'(k * 37 + 5);
            bus.y_in      = 7'(k * 11 + 3);
            bus.colour_in = 3'(k);
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.colour_out !== 3'd0) begin
            bad++;
            $display("FAIL scramble_done got done=%b c=%0d want 1 0", bus.done, bus.colour_out);
        end
        tick();
    endtask

    initial begin
        bus.start = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
        test_reset();
        test_basic();
        test_start_held();
        test_reset_mid();
        test_erase();
        test_clip();
        test_wrap();
        test_scramble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
